// File: rtl/sig_gen_multi.sv
// Square-wave test-signal generator with four selectable periods and glitch-free period switching.
// Supports continuous (enable-driven) and counted-burst runs; it reports period ticks, busy and completed periods.
module sig_gen_multi #(
  parameter int CNT_W   = 21,
  parameter int DIV0    = 32000,
  parameter int DIV1    = 16000,
  parameter int DIV2    = 2000000,
  parameter int DIV3    = 8000,
  parameter int BURST_W = 8
) (
  input  logic               sysclk,
  input  logic               rst_n,
  input  logic [1:0]         testmode,
  input  logic               mode_burst,
  input  logic               enable,
  input  logic               start,
  input  logic [BURST_W-1:0] burst_len,
  output logic               sigin,
  output logic               period_tick,
  output logic               busy,
  output logic [BURST_W-1:0] pulse_cnt
);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(1);
  localparam logic [BURST_W-1:0] BURST_ONE = BURST_W'(1);

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   r_p_act;
  logic [BURST_W-1:0] r_remain;
  logic [BURST_W-1:0] r_pulse_cnt;
  logic               r_burst_run;
  logic               r_sigin;

  logic               w_last;
  logic               w_continue;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic [CNT_W-1:0]   w_half;

  function automatic logic [CNT_W-1:0] div_sel(input logic [1:0] sel);
    case (sel)
      2'b00:   return CNT_W'(DIV0);
      2'b01:   return CNT_W'(DIV1);
      2'b10:   return CNT_W'(DIV2);
      default: return CNT_W'(DIV3);
    endcase
  endfunction

  assign w_last     = (r_state == S_RUN) && (r_cnt == (r_p_act - CNT_ONE));
  assign w_cnt_nxt  = r_cnt + CNT_ONE;
  assign w_half     = r_p_act >> 1;
  // A burst run ignores enable; a continuous run ignores remain.
  assign w_continue = r_burst_run ? (r_remain > BURST_ONE) : enable;

  always_ff @(posedge sysclk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_p_act     <= CNT_W'(DIV0);
      r_remain    <= '0;
      r_burst_run <= 1'b0;
      r_sigin     <= 1'b0;
      r_pulse_cnt <= '0;
    end else if (r_state == S_IDLE) begin
      if (!mode_burst && enable) begin
        r_state     <= S_RUN;
        r_cnt       <= '0;
        r_p_act     <= div_sel(testmode);
        r_pulse_cnt <= '0;
        r_burst_run <= 1'b0;
        r_sigin     <= 1'b1;
      end else if (mode_burst && start && (burst_len != '0)) begin
        r_state     <= S_RUN;
        r_cnt       <= '0;
        r_p_act     <= div_sel(testmode);
        r_pulse_cnt <= '0;
        r_burst_run <= 1'b1;
        r_remain    <= burst_len;
        r_sigin     <= 1'b1;
      end
    end else if (w_last) begin
      r_pulse_cnt <= r_pulse_cnt + BURST_ONE;
      r_cnt       <= '0;
      if (w_continue) begin
        // New period: testmode only takes effect here, so no runt pulses.
        r_p_act <= div_sel(testmode);
        r_sigin <= 1'b1;
        if (r_burst_run) r_remain <= r_remain - BURST_ONE;
      end else begin
        r_state <= S_IDLE;
        r_sigin <= 1'b0;
      end
    end else begin
      r_cnt   <= w_cnt_nxt;
      r_sigin <= (w_cnt_nxt < w_half);
    end
  end

  assign sigin       = r_sigin;
  assign period_tick = w_last;
  assign busy        = (r_state == S_RUN);
  assign pulse_cnt   = r_pulse_cnt;

endmodule

// File: doc/sig_gen_multi.md
# sig_gen_multi

Parametrised test-signal generator for the reaction/frequency measurement path, clocked from the 100 MHz `sysclk`. It produces a square wave whose period is selected by `testmode` from four parameterised dividers. Frequency changes are glitch-free because a new `testmode` takes effect only at a period boundary. Continuous and counted-burst modes are supported, with a period tick, busy flag and completed-period counter for the measurement logic downstream.

## Interface
- `CNT_W`, 21: width of the period counter and of the divider values.
- `DIV0`, 32000: period in `sysclk` cycles for `testmode`=00 (3125 Hz).
- `DIV1`, 16000: period for `testmode`=01 (6250 Hz).
- `DIV2`, 2000000: period for `testmode`=10 (50 Hz).
- `DIV3`, 8000: period for `testmode`=11 (12500 Hz).
- `BURST_W`, 8: width of `burst_len` and `pulse_cnt`.
- Constraint: every DIVn must satisfy 2 ≤ DIVn ≤ 2^CNT_W−1. Out-of-range values are a configuration error and are not handled at runtime.
- `sysclk`, in, 1: system clock, 100 MHz. This is the only clock.
- `rst_n`, in, 1: synchronous, active-low reset.
- `testmode`, in, 2: period select. It is sampled only at a run start and at each period boundary.
- `mode_burst`, in, 1: run-type select, sampled in IDLE only. 0 selects continuous mode; 1 selects burst mode.
- `enable`, in, 1: level-sensitive run request for continuous mode.
- `start`, in, 1: single-cycle burst start request.
- `burst_len`, in, BURST_W: number of periods in a burst, sampled together with `start`.
- `sigin`, out, 1: generated test signal (registered).
- `period_tick`, out, 1: high during the last cycle of each period.
- `busy`, out, 1: high while in the RUN state.
- `pulse_cnt`, out, BURST_W: number of completed periods since the last run start. Wraps modulo 2^BURST_W.

## Operation
- Two states: IDLE and RUN.
- Registers:
  - `cnt`: position within the current period, 0..P−1.
  - `p_act`: active period P.
  - `remain`: periods left in a burst.
  - `burst_run`: run type latched at start.
- Reset values: state=IDLE, cnt=0, p_act=DIV0, remain=0, burst_run=0, sigin=0, period_tick=0, busy=0, pulse_cnt=0.
- `rst_n` has priority over all other inputs. Reset asserted mid-period returns every register to its reset value at the next edge, with no completion of the current period.
- IDLE → RUN, continuous: taken when `mode_burst`=0 and `enable`=1.
- IDLE → RUN, burst: taken when `mode_burst`=1, `start`=1 and `burst_len`≠0. Latches remain=`burst_len`.
- A burst start with `burst_len`=0 is ignored; the block stays in IDLE.
- On entry to RUN:
  - cnt=0, p_act is loaded from `testmode`, pulse_cnt=0, burst_run is latched.
- Waveform within a period: H = P>>1 and L = P−H. `sigin`=1 for cnt 0..H−1 and 0 for cnt H..P−1. For odd P the low phase is one cycle longer.
- `period_tick`=1 exactly when state=RUN and cnt=P−1.
- Boundary rule: at cnt=P−1, pulse_cnt increments. Then:
  - Continuous run with `enable`=1: cnt=0 and p_act is reloaded from the current `testmode`.
  - Continuous run with `enable`=0: go to IDLE with sigin=0.
  - Burst run with remain>1: remain decrements, cnt=0 and p_act is reloaded.
  - Burst run with remain=1: go to IDLE with sigin=0.
- `enable` falling mid-period: the current period always completes. There is no truncated pulse.
- While in RUN, `start`, `mode_burst` and `burst_len` are ignored, and a burst run ignores `enable`.
- `testmode` changes mid-period have no effect until the next boundary.

## Timing
- Start latency: the request is sampled at edge k. At edge k+1, busy=1, cnt=0 and sigin=1, so `sigin` rises 1 cycle after the request.
- Each period lasts exactly P cycles. Back-to-back periods have no gap cycle.
- `period_tick` is a 1-cycle pulse and coincides with the last low cycle of `sigin`.
- pulse_cnt and state update on the edge that ends the tick cycle.
- Stop: when the final period ends at edge m, busy=0 and sigin=0 from edge m onward.
- A new run may start on the first IDLE cycle after a stop: with `enable` still high, sigin rises one cycle after busy fell.
- All outputs are registered or decoded from registers only. There is no combinational path from any input to any output.

## Test plan
- Bench parameters: DIV0=4, DIV1=5, DIV2=8, DIV3=2, BURST_W=4.
- Reset then continuous run: testmode=00, enable=1 → sigin pattern 1100 repeating; period_tick every 4th cycle; pulse_cnt 1, 2, 3 …
- Odd divider: testmode=01 → sigin pattern 11000; tick on cnt=4.
- Glitch-free mode switch: change testmode 00→10 at cnt=1 → the current 4-cycle period completes, then 11110000 follows with no runt pulse.
- Burst: mode_burst=1, start pulse with burst_len=3, testmode=11 → sigin 101010; busy high for 6 cycles; pulse_cnt=3; then IDLE. Repeat with burst_len=0 → busy stays 0.
- Enable drop mid-period at cnt=1, DIV0 → sigin finishes 00; busy falls after the tick; there is no further pulse.
- Reset mid-run: rst_n=0 for 1 cycle at cnt=2 → next cycle sigin=0, busy=0, pulse_cnt=0. Then with enable held at 1, sigin restarts one cycle after rst_n returns high.
